// File: rtl/tone_pkg.sv
// Shared types, note table and helpers for the tone generator.
// Note table entries are half-periods in clock cycles at 100 MHz.
package tone_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY    = 2'd1,
      RELEASE = 2'd2
   } tone_state_t;

   localparam int unsigned NUM_NOTES = 8;

   // C4 D4 E4 F4 G4 A4 B4 C5
   localparam logic [17:0] NOTE_HALF [0:NUM_NOTES-1] = '{
      18'd191110, 18'd170266, 18'd151685, 18'd143172,
      18'd127551, 18'd113636, 18'd101239, 18'd95557
   };

   function automatic logic note_valid(input logic [3:0] key);
      return key < 4'(NUM_NOTES);
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter plus speaker toggle flop.
// A clear forces the counter and the output low; otherwise the flop toggles
// every i_half cycles while enabled, giving a 50% duty square wave.
module tone_divider #(
   parameter int unsigned CNT_W = 18
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_half,
   output logic             o_speaker
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_speaker;
   logic             w_wrap;

   assign w_wrap    = (r_cnt == i_half - CNT_W'(1));
   assign o_speaker = r_speaker;

   // Counter and toggle flop; clear has priority over counting.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_speaker <= 1'b0;
      end else if (i_clr) begin
         r_cnt     <= '0;
         r_speaker <= 1'b0;
      end else if (i_en) begin
         if (w_wrap) begin
            r_cnt     <= '0;
            r_speaker <= ~r_speaker;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator driven by a key_on/key note stream.
// Optional release tail enabled by defining TONE_RELEASE_EN.
// DIV_SHIFT right-shifts every table half-period (0 keeps true pitches).
module tone_gen
   import tone_pkg::*;
#(
   parameter int unsigned CNT_W          = 18,
   parameter int unsigned RELEASE_CYCLES = 5_000_000,
   parameter int unsigned DIV_SHIFT      = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_key_on,
   input  logic [3:0] i_key,
   output logic       o_speaker,
   output logic       o_playing,
   output logic [3:0] o_note
);

   tone_state_t      r_state;
   tone_state_t      w_state_d;
   logic             r_key_on_d;
   logic             r_armed;
   logic [3:0]       r_note;
   logic [CNT_W-1:0] r_half;
   logic             w_rise;
   logic             w_fall;
   logic             w_valid;
   logic             w_div_en;
   logic             w_div_clr;

   // r_armed stays low until key_on is seen low after reset, so a gate held
   // high through reset never counts as a rising edge.
   assign w_rise   = i_key_on & ~r_key_on_d & r_armed;
   assign w_fall   = ~i_key_on & r_key_on_d;
   assign w_valid  = note_valid(i_key);
   assign w_div_en = (r_state != IDLE);

   assign o_playing = (r_state != IDLE);
   assign o_note    = r_note;

`ifdef TONE_RELEASE_EN
   localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

   logic [REL_W-1:0] r_rel_cnt;
   logic             w_rel_done;

   assign w_rel_done = (r_rel_cnt == REL_W'(RELEASE_CYCLES - 1));

   // Release counter runs only while in RELEASE; any exit restarts it at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rel_cnt <= '0;
      end else if (r_state == RELEASE && !w_rel_done && !(w_rise && w_valid)) begin
         r_rel_cnt <= r_rel_cnt + REL_W'(1);
      end else begin
         r_rel_cnt <= '0;
      end
   end
`else
   logic w_unused_rel;
   assign w_unused_rel = (RELEASE_CYCLES == 0);
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next state and divider clear; a valid rise always retriggers.
   always_comb begin
      w_state_d = r_state;
      w_div_clr = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_rise && w_valid) begin
               w_state_d = PLAY;
               w_div_clr = 1'b1;
            end
         end
         PLAY: begin
            if (w_rise && w_valid) begin
               w_div_clr = 1'b1;
            end else if (w_fall) begin
`ifdef TONE_RELEASE_EN
               w_state_d = RELEASE;
`else
               w_state_d = IDLE;
               w_div_clr = 1'b1;
`endif
            end
         end
`ifdef TONE_RELEASE_EN
         RELEASE: begin
            if (w_rise && w_valid) begin
               w_state_d = PLAY;
               w_div_clr = 1'b1;
            end else if (w_rel_done) begin
               w_state_d = IDLE;
               w_div_clr = 1'b1;
            end
         end
`endif
         default: begin
            w_state_d = IDLE;
            w_div_clr = 1'b1;
         end
      endcase
   end

   // Gate edge detect plus note and half-period latches.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_on_d <= 1'b0;
         r_armed    <= 1'b0;
         r_note     <= 4'd0;
         r_half     <= '0;
      end else begin
         r_key_on_d <= i_key_on;
         r_armed    <= r_armed | ~i_key_on;
         if (w_rise) begin
            r_note <= i_key;
         end
         if (w_rise && w_valid) begin
            r_half <= CNT_W'(NOTE_HALF[i_key[2:0]] >> DIV_SHIFT);
         end
      end
   end

   tone_divider #(
      .CNT_W (CNT_W)
   ) u_divider (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (w_div_en),
      .i_clr     (w_div_clr),
      .i_half    (r_half),
      .o_speaker (o_speaker)
   );

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen with a cycle-indexed behavioural model.
module tb_tone_gen;

   localparam int unsigned SHIFT = 10;
   localparam int unsigned REL   = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_on = 1'b0;
   logic [3:0] key = 4'd0;
   logic       o_speaker;
   logic       o_playing;
   logic [3:0] o_note;

   int n_checks = 0;
   int n_errors = 0;

   int unsigned tbl [8] = '{191110, 170266, 151685, 143172, 127551, 113636, 101239, 95557};

   // Model: a note is described by its start cycle and half-period only.
   int   cyc = 0;
   bit   m_prev = 1'b1;
   bit   m_active = 1'b0;
   bit   m_rel = 1'b0;
   int   m_start = 0;
   int   m_half = 1;
   int   m_rel_end = 0;
   logic [3:0] m_note = 4'd0;
   logic exp_spk, exp_play;
   logic [3:0] exp_note;

   always #5 clk = ~clk;

   tone_gen #(
      .CNT_W          (18),
      .RELEASE_CYCLES (REL),
      .DIV_SHIFT      (SHIFT)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_key_on  (key_on),
      .i_key     (key),
      .o_speaker (o_speaker),
      .o_playing (o_playing),
      .o_note    (o_note)
   );

   function automatic void model_reset();
      m_prev = 1'b1;
      m_active = 1'b0;
      m_rel = 1'b0;
      m_note = 4'd0;
      exp_spk = 1'b0;
      exp_play = 1'b0;
      exp_note = 4'd0;
   endfunction

   // One clock edge: update the model from the inputs present at the edge.
   task automatic tick();
      bit rise, fall;
      @(posedge clk);
      rise = key_on && !m_prev;
      fall = !key_on && m_prev;
      m_prev = key_on;
      cyc++;
      if (rise) begin
         m_note = key;
         if (key < 8) begin
            m_active = 1'b1;
            m_rel = 1'b0;
            m_start = cyc;
            m_half = int'(tbl[key[2:0]] >> SHIFT);
         end
      end else if (fall && m_active && !m_rel) begin
`ifdef TONE_RELEASE_EN
         m_rel = 1'b1;
         m_rel_end = cyc + int'(REL);
`else
         m_active = 1'b0;
`endif
      end
      if (m_active && m_rel && cyc >= m_rel_end) m_active = 1'b0;
      exp_play = m_active;
      exp_spk = m_active ? 1'(((cyc - m_start) / m_half) % 2) : 1'b0;
      exp_note = m_note;
      #1;
   endtask

   task automatic test_reset();
      key_on = 1'b1;
      key = 4'd5;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (o_speaker !== 1'b0 || o_playing !== 1'b0 || o_note !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_vals: got spk=%b play=%b note=%0d, want 0 0 0",
                  o_speaker, o_playing, o_note);
      end
      rst_n = 1'b1;
      // Gate held high through reset must not start a note.
      repeat (20) begin
         tick();
         n_checks++;
         if (o_playing !== exp_play || o_speaker !== exp_spk) begin
            n_errors++;
            $display("FAIL reset_held: got play=%b spk=%b, want %b %b",
                     o_playing, o_speaker, exp_play, exp_spk);
         end
      end
      key_on = 1'b0;
      tick();
   endtask

   task automatic test_key5();
      key = 4'd5;
      key_on = 1'b1;
      tick();
      n_checks++;
      if (o_playing !== 1'b1 || o_note !== 4'd5) begin
         n_errors++;
         $display("FAIL start_latency: got play=%b note=%0d, want 1 5", o_playing, o_note);
      end
      repeat (4 * 110 + 3) begin
         tick();
         n_checks++;
         if (o_speaker !== exp_spk || o_playing !== exp_play) begin
            n_errors++;
            $display("FAIL key5_tone @%0d: got spk=%b play=%b, want %b %b",
                     cyc, o_speaker, o_playing, exp_spk, exp_play);
         end
      end
   endtask

   task automatic test_stop_and_hold();
      key_on = 1'b0;
      tick();
      key = 4'd0;
      key_on = 1'b1;
      tick();
      // Key changes while gated high must leave the period alone.
      repeat (500) begin
         key = 4'($urandom_range(0, 15));
         tick();
         n_checks++;
         if (o_speaker !== exp_spk || o_note !== 4'd0) begin
            n_errors++;
            $display("FAIL hold_key @%0d: got spk=%b note=%0d, want %b 0",
                     cyc, o_speaker, o_note, exp_spk);
         end
      end
      key_on = 1'b0;
      tick();
      n_checks++;
      if (o_playing !== exp_play || o_speaker !== exp_spk) begin
         n_errors++;
         $display("FAIL stop: got play=%b spk=%b, want %b %b",
                  o_playing, o_speaker, exp_play, exp_spk);
      end
   endtask

   task automatic test_retrigger();
      repeat (200) tick();
      key = 4'd2;
      key_on = 1'b1;
      repeat (200) tick();
      key_on = 1'b0;
      tick();
      key = 4'd4;
      key_on = 1'b1;
      tick();
      n_checks++;
      if (o_speaker !== 1'b0 || o_playing !== 1'b1 || o_note !== 4'd4) begin
         n_errors++;
         $display("FAIL retrig_clear: got spk=%b play=%b note=%0d, want 0 1 4",
                  o_speaker, o_playing, o_note);
      end
      repeat (4 * 124 + 2) begin
         tick();
         n_checks++;
         if (o_speaker !== exp_spk) begin
            n_errors++;
            $display("FAIL retrig_tone @%0d: got spk=%b, want %b", cyc, o_speaker, exp_spk);
         end
      end
   endtask

   task automatic test_invalid();
      key_on = 1'b0;
      repeat (300) tick();
      key = 4'd9;
      key_on = 1'b1;
      repeat (30) begin
         tick();
         n_checks++;
         if (o_note !== 4'd9 || o_playing !== 1'b0 || o_speaker !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_idle: got note=%0d play=%b spk=%b, want 9 0 0",
                     o_note, o_playing, o_speaker);
         end
      end
      key_on = 1'b0;
      tick();
      key = 4'd3;
      key_on = 1'b1;
      repeat (100) tick();
      key_on = 1'b0;
      tick();
      key = 4'd9;
      key_on = 1'b1;
      repeat (300) begin
         tick();
         n_checks++;
         if (o_note !== exp_note || o_playing !== exp_play || o_speaker !== exp_spk) begin
            n_errors++;
            $display("FAIL invalid_play @%0d: got note=%0d play=%b spk=%b, want %0d %b %b",
                     cyc, o_note, o_playing, o_speaker, exp_note, exp_play, exp_spk);
         end
      end
   endtask

   task automatic test_midreset();
      key_on = 1'b0;
      tick();
      key = 4'd1;
      key_on = 1'b1;
      repeat (100) tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (o_speaker !== 1'b0 || o_playing !== 1'b0 || o_note !== 4'd0) begin
         n_errors++;
         $display("FAIL midreset: got spk=%b play=%b note=%0d, want 0 0 0",
                  o_speaker, o_playing, o_note);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (30) begin
         tick();
         n_checks++;
         if (o_playing !== 1'b0 || o_speaker !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_held: got play=%b spk=%b, want 0 0", o_playing, o_speaker);
         end
      end
      key_on = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 40; seg++) begin
         key_on = ~key_on;
         if (key_on) key = 4'($urandom_range(0, 15));
         repeat ($urandom_range(1, 250)) begin
            tick();
            n_checks++;
            if (o_speaker !== exp_spk || o_playing !== exp_play || o_note !== exp_note) begin
               n_errors++;
               $display("FAIL random @%0d: got spk=%b play=%b note=%0d, want %b %b %0d",
                        cyc, o_speaker, o_playing, o_note, exp_spk, exp_play, exp_note);
            end
         end
      end
      key_on = 1'b0;
      repeat (REL + 5) tick();
   endtask

`ifdef TONE_RELEASE_EN
   task automatic test_release();
      int n;
      key = 4'd6;
      key_on = 1'b1;
      repeat (150) tick();
      key_on = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         n_checks++;
         if (o_speaker !== exp_spk) begin
            n_errors++;
            $display("FAIL release_tone @%0d: got spk=%b, want %b", cyc, o_speaker, exp_spk);
         end
      end while (o_playing === 1'b1 && n < 300);
      n_checks++;
      if (n != int'(REL) + 1) begin
         n_errors++;
         $display("FAIL release_len: got %0d cycles, want %0d", n, REL + 1);
      end
      key = 4'd2;
      key_on = 1'b1;
      repeat (10) tick();
      key_on = 1'b0;
      repeat (51) tick();
      key = 4'd7;
      key_on = 1'b1;
      repeat (300) begin
         tick();
         n_checks++;
         if (o_playing !== 1'b1 || o_note !== 4'd7 || o_speaker !== exp_spk) begin
            n_errors++;
            $display("FAIL release_retrig @%0d: got play=%b note=%0d spk=%b, want 1 7 %b",
                     cyc, o_playing, o_note, o_speaker, exp_spk);
         end
      end
      key_on = 1'b0;
      repeat (REL + 5) tick();
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_key5();
      test_stop_and_hold();
      test_retrigger();
      test_invalid();
      test_midreset();
      test_random();
`ifdef TONE_RELEASE_EN
      test_release();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tone_gen.md
# tone_gen

Downstream stage of the song player: consumes the `key_on`/`key[3:0]` note stream and drives a square-wave audio output for the board buzzer. It has these duties:
- latch the note index on each `key_on` rising edge;
- look up that note's half-period in clock cycles;
- toggle `speaker` at that rate while the note is active.

It is a single-clock design with an explicit state machine, a retrigger rule and an optional release tail.

## Interface
- `CNT_W`, default 18: half-period counter width; must hold 191110.
- `RELEASE_CYCLES`, default 5_000_000: release-tail length in cycles (50 ms at 100 MHz). Used only with `TONE_RELEASE_EN`.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `key_on` in 1: note gate, synchronous to `clk`.
- `key` in 4: note index; sampled only on the `key_on` rising edge.
- `speaker` out 1: square-wave audio output.
- `playing` out 1: high while in PLAY or RELEASE.
- `note` out 4: latched note index.

## Operation
- **Note table, half-period counts at 100 MHz:**
  - 0=C4 191110, 1=D4 170266, 2=E4 151685, 3=F4 143172
  - 4=G4 127551, 5=A4 113636, 6=B4 101239, 7=C5 95557
  - Keys 8–15 are invalid.
- **Edge detect:** register `key_on_d`. `rise = key_on & ~key_on_d`, `fall = ~key_on & key_on_d`.
- **States:** IDLE, PLAY, RELEASE (RELEASE exists only with the macro).
- **IDLE:**
  - On `rise` with a valid key → PLAY.
  - On `rise` with an invalid key → stay IDLE; `note` still latches.
- **PLAY:**
  - On `fall` → RELEASE (macro on) or IDLE (macro off).
  - On `rise` → retrigger, see below.
- **RELEASE:**
  - The tone keeps toggling while the release counter counts 0..RELEASE_CYCLES-1, then → IDLE.
  - On `rise` → retrigger into PLAY.
- **Retrigger, from any state on `rise` with a valid key:**
  - latch `note<=key` and `half<=table[key]`;
  - clear `cnt` and the release counter;
  - set `speaker<=0`.
- **Tone counter in PLAY/RELEASE:**
  - `cnt` increments each cycle.
  - At `cnt==half-1`: `cnt<=0` and `speaker` toggles.
  - Output period is `2*half` cycles at 50% duty.
- **Leaving PLAY/RELEASE to IDLE:** `speaker<=0`, `cnt<=0`.
- **Ignored inputs:** changes on `key` while `key_on` stays high; an invalid key on `rise` while playing (state and tone unchanged, `note` still latches).
- **Simultaneous events:**
  - `rise` and release expiry in the same cycle → `rise` wins.
  - A `rise`/`fall` pulse of one cycle: `rise` moves to PLAY; `fall` on the next cycle is handled normally.

## Timing
- **Reset values:**
  - `speaker=0`, `playing=0`, `note=0`
  - state IDLE, `cnt=0`, `key_on_d=0`
- **Start latency:** `key_on` high in cycle N (`key_on_d` low) → PLAY and `playing=1` in N+1. First `speaker` rise at N+1+half.
- **Stop latency, macro off:** `key_on` low in cycle M → `playing=0`, `speaker=0` in M+1.
- **Stop latency, macro on:** `playing` drops at M+1+RELEASE_CYCLES.
- **Mid-operation reset:** asserting `rst` returns all outputs to reset values immediately, regardless of state. After deassert, the first `rise` needs `key_on_d=0`, so a `key_on` held high through reset does not start a note.

## Configuration
- Macro: `TONE_RELEASE_EN`.
- **Defined:** RELEASE state and release counter (width covers RELEASE_CYCLES-1) are present. The tone sustains `RELEASE_CYCLES` after the gate drops, masking the gap between repeated notes.
- **Undefined:** RELEASE and its counter are absent. `fall` goes PLAY → IDLE directly, and `RELEASE_CYCLES` is unused.

## Structure
- **Package `tone_pkg`:**
  - state enum `tone_state_t` (IDLE, PLAY, RELEASE);
  - `NOTE_HALF[0:7]` constant table;
  - `NUM_NOTES=8`;
  - function `note_valid(key)` (key < 8).
- **Sub-module `tone_divider`:** the half-period counter plus toggle flop, with inputs `en`, `clr`, `half`.
- **`tone_gen` itself:** holds the FSM, edge detect, latches and release counter.

## Test plan
- Reset with `key_on=1` held, deassert `rst` → `speaker=0`, `playing=0`, and no note starts until `key_on` drops and rises again.
- `key=5`, `key_on` rises at cycle N → `playing=1` at N+1. `speaker` toggles at N+1+113636 and every 113636 cycles after.
- Macro off, key 0 playing, `key_on` falls at M → `playing=0`, `speaker=0` at M+1. Change `key` while gated high → period unchanged.
- `key=2` playing, drop and re-raise `key_on` with `key=4` → `speaker` cleared on retrigger, new period 2×127551.
- `key=9` on `rise` from IDLE → stay IDLE, `note=9`, `speaker` stays 0. `key=9` while playing key 3 → key 3 tone continues.
- Macro on, `RELEASE_CYCLES=100`: `fall` → tone continues, `playing=0` exactly 101 cycles after `fall`. A new `rise` at release count 50 → PLAY with the new note.
